// File: rtl/multi_waterfall_if.sv
// multi_waterfall_if: groups the raster, sample-sink and display signals
// of the multi-channel waterfall renderer.
//   master : sample sources + display timing (drive raster/sink, read display)
//   slave  : the waterfall block itself
// Signals:
//   h_pos/v_pos/valid_draw/end_cycle  raster position and frame timing
//   sink_valid/sink_data              per-channel sample strobes and samples
//   disp_red/green/blue               registered pixel colour
//   frame_count/overrun               frame counter, sticky per-channel overrun
interface multi_waterfall_if #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 16
);
  logic [9:0]               h_pos;
  logic [9:0]               v_pos;
  logic                     valid_draw;
  logic                     end_cycle;
  logic [CHANNELS-1:0]      sink_valid;
  logic [CHANNELS*DATA_W-1:0] sink_data;
  logic [7:0]               disp_red;
  logic [7:0]               disp_green;
  logic [7:0]               disp_blue;
  logic [11:0]              frame_count;
  logic [CHANNELS-1:0]      overrun;

  modport master (
    output h_pos, v_pos, valid_draw, end_cycle, sink_valid, sink_data,
    input  disp_red, disp_green, disp_blue, frame_count, overrun
  );

  modport slave (
    input  h_pos, v_pos, valid_draw, end_cycle, sink_valid, sink_data,
    output disp_red, disp_green, disp_blue, frame_count, overrun
  );
endinterface

// File: rtl/multi_waterfall.sv
// multi_waterfall: buffers CHANNELS signed sample streams in per-channel
// circular column buffers and renders each channel as a vertical strip of
// the raster (newest sample on row 0, scrolling once per frame).
// Ports:
//   clk    system/display clock
//   reset  synchronous active-high reset
//   bus    multi_waterfall_if.slave (raster in, samples in, pixels/status out)
// Pixel latency is a fixed 2 cycles from h_pos/v_pos/valid_draw to disp_*.
// Build option: define WATERFALL_HEATMAP_EN to map intensity through a
// blue-green-red heat map instead of grayscale.
module multi_waterfall #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 256,
  parameter int STRIP_W  = 320
) (
  input  logic              clk,
  input  logic              reset,
  multi_waterfall_if.slave  bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 2);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEPTH + 1);

  logic [CHANNELS*DATA_W-1:0] rd_all;
  logic [CHANNELS-1:0]        overrun_all;

  // Stage 1: strip select and range test
  logic [CHW-1:0] ch_d, ch_q;
  logic           in_range_d, in_range_q;

  always_comb begin
    ch_d = '0;
    for (int k = 1; k < CHANNELS; k++) begin
      if ({1'b0, bus.h_pos} >= 11'(k * STRIP_W)) ch_d = CHW'(k);
    end
    in_range_d = bus.valid_draw
              && ({1'b0, bus.h_pos} < 11'(CHANNELS * STRIP_W))
              && ({1'b0, bus.v_pos} < 11'(DEPTH));
  end

  // Every channel reads its own row each cycle; stage 2 picks the strip.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, snap_ptr_q, rd_addr;
    logic [CW-1:0]     count_q;
    logic              overrun_q;
    logic [DATA_W-1:0] rd_q;
    logic              wr_en;

    assign wr_en   = bus.sink_valid[k] && !reset;
    assign rd_addr = snap_ptr_q - AW'(1) - bus.v_pos[AW-1:0];

    // Non-blocking read gives old data on a same-address write.
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= bus.sink_data[k*DATA_W +: DATA_W];
      rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q   <= '0;
        snap_ptr_q <= '0;
        count_q    <= '0;
        overrun_q  <= 1'b0;
      end else begin
        if (bus.sink_valid[k]) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (bus.end_cycle) begin
          // Pre-increment pointer: a sample landing this cycle belongs to the next frame.
          snap_ptr_q <= wr_ptr_q;
          count_q    <= bus.sink_valid[k] ? CW'(1) : '0;
          overrun_q  <= 1'b0;
        end else if (bus.sink_valid[k]) begin
          if (count_q != CNT_SAT) count_q <= count_q + CW'(1);
          if (count_q == CNT_FULL) overrun_q <= 1'b1;
        end
      end
    end

    assign rd_all[k*DATA_W +: DATA_W] = rd_q;
    assign overrun_all[k]             = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q       <= '0;
      in_range_q <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      in_range_q <= in_range_d;
    end
  end

  // Stage 2: magnitude, intensity, colour
  logic [DATA_W-1:0] sel_sample, mag;
  logic [DATA_W:0]   mag_ext;
  logic [7:0]        inten;
  logic [23:0]       rgb_d, rgb_q;
  logic              unused_mag;

  always_comb begin
    sel_sample = rd_all[int'(ch_q)*DATA_W +: DATA_W];
    if (sel_sample == {1'b1, {(DATA_W-1){1'b0}}})
      mag = {1'b0, {(DATA_W-1){1'b1}}};
    else if (sel_sample[DATA_W-1])
      mag = -sel_sample;
    else
      mag = sel_sample;
  end

  // Padding by one bit keeps the unused-bit slice legal down to DATA_W=9.
  assign mag_ext    = {mag, 1'b0};
  assign inten      = mag_ext[DATA_W-1 -: 8];
  assign unused_mag = ^{mag_ext[DATA_W], mag_ext[DATA_W-9:0]};

  always_comb begin
`ifdef WATERFALL_HEATMAP_EN
    if (!inten[7])
      rgb_d = {8'h00, {inten[6:0], 1'b0}, 8'hFF - {inten[6:0], 1'b0}};
    else
      rgb_d = {{inten[6:0], 1'b0}, 8'hFF - {inten[6:0], 1'b0}, 8'h00};
`else
    rgb_d = {inten, inten, inten};
`endif
    if (!in_range_q) rgb_d = '0;
  end

  logic [11:0] frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      frame_q <= '0;
    end else begin
      rgb_q <= rgb_d;
      if (bus.end_cycle) frame_q <= frame_q + 12'd1;
    end
  end

  assign bus.disp_red    = rgb_q[23:16];
  assign bus.disp_green  = rgb_q[15:8];
  assign bus.disp_blue   = rgb_q[7:0];
  assign bus.frame_count = frame_q;
  assign bus.overrun     = overrun_all;
endmodule

// File: tb/tb_multi_waterfall.sv
// Self-checking bench for multi_waterfall. The reference model keeps the full
// sample history of each channel plus the history length at the last frame
// snapshot; row r of a strip is the (r+1)-th newest sample of that snapshot.
module tb_multi_waterfall;
  localparam int CH = 2, DW = 16, DEPTH = 32, SW = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_waterfall_if #(.CHANNELS(CH), .DATA_W(DW)) bus ();

  multi_waterfall #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH), .STRIP_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] hist [CH][$];
  int snap_n [CH];
  int cnt    [CH];
  bit ov     [CH];
  int frames;
  int checks = 0;
  int errors = 0;

  function automatic logic [23:0] colour(input logic [DW-1:0] s);
    int v, m, i;
    v = $signed(s);
    m = (v < 0) ? -v : v;
    if (m > (1 << (DW-1)) - 1) m = (1 << (DW-1)) - 1;
    i = (m >> (DW-9)) & 255;
`ifdef WATERFALL_HEATMAP_EN
    if (i < 128) return {8'd0, 8'(2*i), 8'(255 - 2*i)};
    else         return {8'(2*(i-128)), 8'(255 - 2*(i-128)), 8'd0};
`else
    return {8'(i), 8'(i), 8'(i)};
`endif
  endfunction

  function automatic logic [CH-1:0] ov_vec();
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = ov[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given sink/end_cycle inputs; model follows the edge.
  task automatic cycle(input logic [CH-1:0] v, input logic [CH*DW-1:0] d, input bit ec);
    bus.sink_valid = v;
    bus.sink_data  = d;
    bus.end_cycle  = ec;
    @(negedge clk);
    if (ec) begin
      frames = (frames + 1) % 4096;
      for (int k = 0; k < CH; k++) snap_n[k] = hist[k].size();
    end
    for (int k = 0; k < CH; k++) begin
      if (v[k]) hist[k].push_back(d[k*DW +: DW]);
      if (ec) begin
        cnt[k] = v[k] ? 1 : 0;
        ov[k]  = 0;
      end else if (v[k]) begin
        if (cnt[k] == DEPTH) ov[k] = 1;
        if (cnt[k] < DEPTH + 1) cnt[k]++;
      end
    end
    bus.sink_valid = '0;
    bus.end_cycle  = 1'b0;
  endtask

  function automatic logic [CH*DW-1:0] rnd_data();
    logic [CH*DW-1:0] d;
    for (int k = 0; k < CH; k++) d[k*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic pix(input string tag, input int h, input int v, input bit vd);
    bit inr, defd;
    int c, n;
    logic [23:0] exp;
    bus.h_pos = 10'(h);
    bus.v_pos = 10'(v);
    bus.valid_draw = vd;
    @(negedge clk);
    @(negedge clk);
    inr  = vd && (h < CH*SW) && (v < DEPTH);
    defd = 1;
    exp  = '0;
    if (inr) begin
      c = h / SW;
      n = hist[c].size();
      if (v >= snap_n[c] || v >= DEPTH - (n - snap_n[c])) defd = 0;
      else exp = colour(hist[c][snap_n[c] - 1 - v]);
    end
    if (defd) chk(tag, {bus.disp_red, bus.disp_green, bus.disp_blue}, exp);
  endtask

  initial begin
    logic [CH*DW-1:0] d;
    logic [23:0] prev;
    frames = 0;
    for (int k = 0; k < CH; k++) begin snap_n[k] = 0; cnt[k] = 0; ov[k] = 0; end
    reset = 1'b1;
    bus.h_pos = '0; bus.v_pos = '0; bus.valid_draw = 1'b0;
    bus.end_cycle = 1'b0;
    bus.sink_valid = '1;
    bus.sink_data = rnd_data();
    repeat (3) @(negedge clk);
    chk("rst_disp", {bus.disp_red, bus.disp_green, bus.disp_blue}, 0);
    chk("rst_frame", bus.frame_count, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    bus.sink_valid = '0;

    // First sample after reset lands at row 0
    cycle(2'b01, rnd_data(), 1'b0);
    cycle(2'b00, '0, 1'b1);
    pix("rst_row0", 0, 0, 1'b1);

    // Ordering on channel 0
    cycle(2'b01, {16'h0, 16'h1000}, 1'b0);
    cycle(2'b01, {16'h0, 16'h7FFF}, 1'b0);
    cycle(2'b00, '0, 1'b1);
    pix("ord_row0", 0, 0, 1'b1);
    pix("ord_row1", 0, 1, 1'b1);

    // Sign / saturation on channel 1
    cycle(2'b10, {16'h8000, 16'h0}, 1'b0);
    cycle(2'b10, {16'hF000, 16'h0}, 1'b0);
    cycle(2'b00, '0, 1'b1);
    pix("sgn_row0", SW, 0, 1'b1);
    pix("sgn_row1", SW, 1, 1'b1);
    pix("sgn_ch0", SW - 1, 0, 1'b1);
    chk("frame_a", bus.frame_count, frames);

    // Bounds
    pix("bnd_h", CH*SW, 0, 1'b1);
    pix("bnd_v", 0, DEPTH, 1'b1);
    pix("bnd_vd", 0, 0, 1'b0);

    // Exact 2-cycle latency: bright pixel, then out-of-range
    pix("lat_on", SW, 1, 1'b1);
    prev = colour(16'h8000);
    bus.valid_draw = 1'b0;
    @(negedge clk);
    chk("lat_hold1", {bus.disp_red, bus.disp_green, bus.disp_blue}, prev);
    @(negedge clk);
    chk("lat_off2", {bus.disp_red, bus.disp_green, bus.disp_blue}, 0);

    // Overrun / wrap on channel 0
    for (int i = 0; i < DEPTH; i++) begin
      d = rnd_data();
      cycle(2'b01, d, 1'b0);
    end
    chk("ovr_pre", bus.overrun, ov_vec());
    cycle(2'b01, rnd_data(), 1'b0);
    chk("ovr_set", bus.overrun, ov_vec());
    chk("ovr_set0", bus.overrun[0], 1'b1);
    cycle(2'b00, '0, 1'b1);
    chk("ovr_clr", bus.overrun, 0);
    for (int r = 0; r < DEPTH; r++) pix("wrap_row", $urandom_range(0, SW-1), r, 1'b1);

    // end_cycle together with a write
    cycle(2'b01, {16'h0, 16'h0000}, 1'b0);
    cycle(2'b00, '0, 1'b1);
    cycle(2'b01, {16'h0, 16'h7FFF}, 1'b1);
    chk("sim_frame", bus.frame_count, frames);
    pix("sim_row0", 0, 0, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) cycle(2'b01, {16'h0, 16'h7FFF}, 1'b0);
    chk("sim_cnt_pre", bus.overrun, ov_vec());
    cycle(2'b01, {16'h0, 16'h7FFF}, 1'b0);
    chk("sim_cnt_set", bus.overrun, ov_vec());
    cycle(2'b00, '0, 1'b1);
    pix("sim_next", 0, 0, 1'b1);

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      int nw;
      nw = $urandom_range(0, DEPTH + 4);
      for (int i = 0; i < nw; i++) cycle(CH'($urandom), rnd_data(), 1'b0);
      chk("rnd_ovr", bus.overrun, ov_vec());
      cycle(CH'($urandom), rnd_data(), 1'b1);
      chk("rnd_frame", bus.frame_count, frames);
      chk("rnd_ovr_clr", bus.overrun, ov_vec());
      for (int p = 0; p < 24; p++)
        pix("rnd_pix", $urandom_range(0, CH*SW + 20), $urandom_range(0, DEPTH + 3),
            $urandom_range(0, 9) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
